// File: rtl/sram_ctrl_gen2.sv
// Asynchronous SRAM controller: turns one 1/2/4-byte bus request into DW-wide SRAM
// beats with programmable read wait and write setup/pulse/hold timing.
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 3
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module sram_ctrl_gen2 #(
    parameter int AW       = 19,
    parameter int DW       = 8,
    parameter int RD_WAIT  = 1,
    parameter int WR_SETUP = 1,
    parameter int WR_PULSE = 1,
    parameter int WR_HOLD  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req,
    input  logic                            wr_b,
    input  logic [$clog2(`BUS_ACC_CNT)-1:0] acc,
    input  logic [AW+DW/16-1:0]             addr,
    input  logic [31:0]                     wdata,
    output logic [31:0]                     rdata,
    output logic                            resp,
    output logic                            fault,
    output logic                            busy,
    output logic                            sram_ce_bar,
    output logic                            sram_oe_bar,
    output logic                            sram_we_bar,
    output logic                            sram_ub_bar,
    output logic                            sram_lb_bar,
    output logic [AW-1:0]                   sram_addr,
    inout  wire  [DW-1:0]                   sram_data
);
    localparam int ACC_W = $clog2(`BUS_ACC_CNT);
    localparam int OFS   = DW / 16;
    localparam int CW    = 16;
    localparam logic [CW-1:0] RD_END = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] SU_END = CW'(WR_SETUP - 1);
    localparam logic [CW-1:0] PW_END = CW'(WR_PULSE - 1);
    localparam logic [CW-1:0] HD_END = CW'(WR_HOLD - 1);
    localparam logic [2:0]    N2     = (DW == 16) ? 3'd1 : 3'd2;
    localparam logic [2:0]    N4     = (DW == 16) ? 3'd2 : 3'd4;

    typedef enum logic [2:0] {IDLE, CHECK, RD, WR_SU, WR_PW, WR_HD, DONE} state_t;
    localparam state_t FIRST_WR = (WR_SETUP > 0) ? WR_SU : WR_PW;

    state_t            state, state_nx;
    logic              wr_l;
    logic [ACC_W-1:0]  acc_l;
    logic [AW+OFS-1:0] addr_l;
    logic [31:0]       wdata_l;
    logic [2:0]        beat, beats;
    logic [CW-1:0]     cnt;
    logic              bad, last_beat, phase_done, beat_done, active, wr_state;
    logic [AW-1:0]     word_addr;
    logic [DW-1:0]     wr_lane;

    // Request decode: alignment/encoding check and beat count
    always_comb begin
        bad   = 1'b0;
        beats = 3'd1;
        case (acc_l)
            `BUS_ACC_1B: beats = 3'd1;
            `BUS_ACC_2B: begin bad = addr_l[0];          beats = N2; end
            `BUS_ACC_4B: begin bad = (addr_l[1:0] != 0); beats = N4; end
            default:     bad = 1'b1;
        endcase
    end

    assign last_beat = (beat == beats - 3'd1);
    assign word_addr = AW'(addr_l >> OFS);
    assign wr_state  = (state == WR_SU) || (state == WR_PW) || (state == WR_HD);

    always_comb begin
        phase_done = 1'b0;
        case (state)
            RD:      phase_done = (cnt == RD_END);
            WR_SU:   phase_done = (cnt == SU_END);
            WR_PW:   phase_done = (cnt == PW_END);
            WR_HD:   phase_done = (cnt == HD_END);
            default: phase_done = 1'b0;
        endcase
        beat_done = phase_done &&
                    ((state == RD) || (state == WR_HD) || (state == WR_PW && WR_HOLD == 0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = CHECK;
            CHECK:   state_nx = bad ? DONE : (wr_l ? FIRST_WR : RD);
            RD:      if (phase_done && last_beat) state_nx = DONE;
            WR_SU:   if (phase_done) state_nx = WR_PW;
            WR_PW:   if (phase_done) begin
                         if (WR_HOLD > 0)    state_nx = WR_HD;
                         else if (last_beat) state_nx = DONE;
                         else                state_nx = FIRST_WR;
                     end
            WR_HD:   if (phase_done) state_nx = last_beat ? DONE : FIRST_WR;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        active      = (state == RD) || wr_state || (state == CHECK && !bad);
        busy        = (state != IDLE);
        resp        = (state == DONE);
        sram_ce_bar = !active;
        sram_oe_bar = (state != RD);
        sram_we_bar = (state != WR_PW);
        sram_addr   = active ? word_addr + AW'(beat) : '0;
        sram_ub_bar = 1'b1;
        sram_lb_bar = 1'b1;
        if (DW == 8) begin
            // 8-bit parts have no lane strobes; pins are parked low outside reset
            sram_ub_bar = rst;
            sram_lb_bar = rst;
        end else if (active) begin
            sram_ub_bar = (acc_l == `BUS_ACC_1B) && !addr_l[0];
            sram_lb_bar = (acc_l == `BUS_ACC_1B) &&  addr_l[0];
        end
    end

    always_comb begin
        if (DW == 16 && acc_l == `BUS_ACC_1B) wr_lane = {(DW/8){wdata_l[7:0]}};
        else                                  wr_lane = wdata_l[beat*DW +: DW];
    end

    assign sram_data = wr_state ? wr_lane : {DW{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            beat  <= '0;
            fault <= 1'b0;
            rdata <= '0;
        end else begin
            if (state == IDLE && req) fault <= 1'b0;
            if (state == CHECK && bad) fault <= 1'b1;
            if (state == RD || wr_state) begin
                cnt <= phase_done ? '0 : cnt + 1'b1;
                if (beat_done) beat <= beat + 3'd1;
            end else begin
                cnt  <= '0;
                beat <= '0;
            end
            if (state == RD && phase_done) begin
                if (DW == 16 && acc_l == `BUS_ACC_1B)
                    rdata[7:0] <= addr_l[0] ? sram_data[DW-1 -: 8] : sram_data[7:0];
                else
                    rdata[beat*DW +: DW] <= sram_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            wr_l    <= wr_b;
            acc_l   <= acc;
            addr_l  <= addr;
            wdata_l <= wdata;
        end
    end
endmodule
